// File: rtl/button_event_unit_pkg.sv
// Shared constants for the alarm-clock button front-end: button indices, event codes
// and a counter-width helper.
package button_event_unit_pkg;

  localparam int NUM_BTN = 5;

  localparam int BTN_C = 0;
  localparam int BTN_R = 1;
  localparam int BTN_L = 2;
  localparam int BTN_U = 3;
  localparam int BTN_D = 4;

  localparam logic [2:0] EVT_C = 3'd0;
  localparam logic [2:0] EVT_R = 3'd1;
  localparam logic [2:0] EVT_L = 3'd2;
  localparam logic [2:0] EVT_U = 3'd3;
  localparam logic [2:0] EVT_D = 3'd4;

  // Width able to hold n-1; never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_event_unit_debounce.sv
// btn_debounce: 2-flop synchroniser, debounce counter and level register for one button.
// reset is asynchronous and active-low.
module btn_debounce
  import button_event_unit_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam int DEB_W = cntWidth(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic r_sync1;
  logic r_sync2;
  logic r_level;
  logic r_press;
  logic [DEB_W-1:0] r_cnt;
  logic w_mismatch;

  assign w_mismatch = r_sync2 ^ r_level;

  // The level flips only after DEB_CYCLES consecutive mismatched edges, so the
  // counter never needs to count past DEB_LAST.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (r_cnt == DEB_LAST) begin
        r_level <= r_sync2;
        r_press <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/button_event_unit.sv
// button_event_unit: debounced buttons -> pending flags -> prioritised valid/ready events.
// Define AUTOREPEAT_EN to build hold/repeat strikes for U and D. reset is async active-low.
module button_event_unit
  import button_event_unit_pkg::*;
#(
  parameter int DEB_CYCLES    = 500000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 15000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               evt_valid,
  output logic [2:0]         evt_code,
  input  logic               evt_ready
);

  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_press;
  logic [NUM_BTN-1:0] w_strike;
  logic [NUM_BTN-1:0] w_sel;
  logic [NUM_BTN-1:0] w_clear;
  logic [2:0]         w_code;
  logic [NUM_BTN-1:0] r_pend;

  for (genvar i = 0; i < NUM_BTN; i++) begin : gBtn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) uDeb (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (btn_raw[i]),
      .o_level (w_level[i]),
      .o_press (w_press[i])
    );
  end

`ifdef AUTOREPEAT_EN
  localparam int HOLD_W = cntWidth(HOLD_CYCLES);
  localparam int RPT_W  = cntWidth(REPEAT_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);

  logic [1:0] w_rptStrike;

  // Hold counter saturates at HOLD_LAST for the first strike, then the repeat
  // counter takes over and reloads after every strike.
  for (genvar j = 0; j < 2; j++) begin : gRepeat
    localparam int B = BTN_U + j;
    logic [HOLD_W-1:0] r_hold;
    logic [RPT_W-1:0]  r_rpt;
    logic              r_rptPhase;

    assign w_rptStrike[j] = w_level[B] &&
                            (r_rptPhase ? (r_rpt == RPT_LAST) : (r_hold == HOLD_LAST));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_hold     <= '0;
        r_rpt      <= '0;
        r_rptPhase <= 1'b0;
      end else if (!w_level[B]) begin
        r_hold     <= '0;
        r_rpt      <= '0;
        r_rptPhase <= 1'b0;
      end else if (!r_rptPhase) begin
        if (r_hold == HOLD_LAST) begin
          r_rptPhase <= 1'b1;
          r_rpt      <= '0;
        end else begin
          r_hold <= r_hold + 1'b1;
        end
      end else if (r_rpt == RPT_LAST) begin
        r_rpt <= '0;
      end else begin
        r_rpt <= r_rpt + 1'b1;
      end
    end
  end

  assign w_strike = {w_rptStrike, 3'b000};
`else
  // No repeat hardware: strikes tie low whatever the hold/repeat parameters say.
  localparam bit NO_REPEAT = (HOLD_CYCLES >= 0) || (REPEAT_CYCLES >= 0) || 1'b1;
  assign w_strike = {NUM_BTN{~NO_REPEAT}};
`endif

  always_comb begin
    w_code = EVT_C;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (r_pend[i]) w_code = 3'(i);
    end
  end

  assign w_sel   = r_pend & (~r_pend + 1'b1);
  assign w_clear = evt_ready ? w_sel : '0;

  // A set on the same edge as an acceptance wins, so nothing is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clear) | w_press | w_strike;
    end
  end

  assign btn_level = w_level;
  assign evt_valid = |r_pend;
  assign evt_code  = w_code;

endmodule
